softmax_exp_accumulator: RTL and testbench
==========================================

Name: softmax_exp_accumulator

Overview:
- Upstream feeder for the 8-by-32 array divider in the softmax datapath.
- Accepts one vector of 8-bit exponential values as a valid/ready stream and buffers every element.
- Accumulates their 32-bit sum, then replays each buffered element with the final sum as a (dividend, divisor) pair, so the divider's quotient is the normalised softmax output.
- One vector in flight: accumulate phase, then drain phase.

Parameters:
- DEPTH, 64, maximum elements per vector (2..2^24; sum cannot overflow 32 bits).
- IDX_W, $clog2(DEPTH), width of element index and count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  8  exponential value, unsigned.
- in_last  in  1  final element of the vector.
- out_valid  out  1  pair valid to divider stage.
- out_ready  in  1  consumer accepts the pair.
- out_x  out  8  buffered element, to divider dividend X.
- out_y  out  32  vector sum, to divider divisor Y.
- out_last  out  1  pair is the final element of the vector.
- out_index  out  IDX_W  element position within the vector, 0-based.
- zero_sum  out  1  out_y == 0; the divider result is meaningless.
- len_error  out  1  one-cycle pulse: the vector was truncated at DEPTH.

Behaviour:
- Reset: clock is clk; reset rst is asynchronous, active-high.
  - Every register clears immediately on reset assertion: state=ACCUM, count=0, sum=0, rd_ptr=0.
  - Output values under reset: in_ready=1, out_valid=0, out_x=0, out_y=0, out_last=0, out_index=0, zero_sum=0, len_error=0.
  - Reset mid-vector or mid-drain discards the vector; buffer contents need not be cleared.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready: buf[count]<=in_data; sum<=sum+{24'b0,in_data}; count<=count+1.
  - The vector ends on a handshake with in_last=1, or on the handshake that fills the buffer (count==DEPTH-1).
  - Truncation: if the buffer fills with in_last=0, len_error pulses for one cycle on the cycle after that handshake. Later beats start the next vector.
  - On vector end: next state is DRAIN, rd_ptr<=0, and the sum register includes the final beat.
- State DRAIN:
  - in_ready=0 and out_valid=1.
  - First out_valid is exactly one cycle after the closing input handshake.
  - Outputs: out_x=buf[rd_ptr], out_y=sum, out_index=rd_ptr.
  - out_last=(rd_ptr==count-1); zero_sum=(sum==0).
  - Outputs hold stable while out_valid&!out_ready.
  - On out_valid&out_ready: rd_ptr<=rd_ptr+1.
  - If out_last is set on that handshake: state<=ACCUM, count<=0, sum<=0, rd_ptr<=0. in_ready returns to 1 on the next cycle.
  - Throughput: one pair per cycle when out_ready is held high.
- Widths and invariants:
  - Sum is unsigned, zero-extended 8-to-32-bit addition with no saturation; overflow is impossible by the DEPTH bound.
  - Invariant out_y >= out_x always holds.
- Boundary cases:
  - A single-element vector drains one beat, with out_last=1 and out_y equal to that element.
  - An all-zero vector sets zero_sum=1 on every drained beat and is still drained in full.
  - in_valid during DRAIN is ignored, with no handshake.
  - in_last on the DEPTH-th beat is a normal close; len_error stays 0.
- Assertions:
  - out_y >= out_x whenever out_valid.
  - No in handshake while in DRAIN.
  - out_* stable under backpressure.

Decomposition:
- Package softmax_pkg:
  - Constants EXP_W=8 and SUM_W=32.
  - Enum state_t {ACCUM, DRAIN}.
  - The divider stage imports the same width constants.
- Sub-module softmax_exp_buffer:
  - Parameterised DEPTH x EXP_W register file.
  - One synchronous write port, one combinational read port.
  - No reset on storage.
- FSM, sum, count and rd_ptr stay in the top module.

Test Plan:
- Basic vector: inputs 10,20,30 with last on 30 and out_ready=1 → three beats (10,60),(20,60),(30,60); out_index 0,1,2; out_last only on the third beat; in_ready back to 1 one cycle after it.
- Backpressure: same vector with out_ready toggling 0/1 each cycle → identical sequence, outputs stable on stalled cycles, no skipped or repeated index.
- Full-scale sum: DEPTH=64 with all elements 255, last on the 64th beat → out_y=16320 on all 64 beats; len_error never pulses.
- Truncation: DEPTH=4, five beats 1,2,3,4,5 with no last → drain 1..4 with sum 10; len_error pulses once; beat 5 then opens a new vector with sum 5.
- Zero-sum and single-element cases: one beat of 0 with last → one out beat x=0, y=0, zero_sum=1, out_last=1. Then one beat of 7 → x=7, y=7, zero_sum=0.
- Reset mid-drain: assert rst at out_index=1 of a 3-element vector → out_valid falls immediately and in_ready=1. A following vector 5,5 drains with sum 10, with no residue from the aborted vector.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared widths and FSM encoding for the softmax datapath
// (exponential accumulator feeding the 8-by-32 array divider).
package softmax_pkg;
  localparam int EXP_W = 8;
  localparam int SUM_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/softmax_exp_buffer.sv
// DEPTH x EXP_W element store: synchronous write, combinational read.
// Storage has no reset; stale entries are never read because the read
// pointer only covers elements written in the current vector.
module softmax_exp_buffer
  import softmax_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [EXP_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [EXP_W-1:0] rd_data
);

  logic [EXP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/softmax_exp_accumulator.sv
// Buffers one vector of exponentials while summing them, then replays each
// element paired with the final sum as (dividend, divisor) for the divider.
module softmax_exp_accumulator
  import softmax_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_x,
  output logic [SUM_W-1:0] out_y,
  output logic             out_last,
  output logic [IDX_W-1:0] out_index,
  output logic             zero_sum,
  output logic             len_error
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holding valid keeps its payload stable until then.

  // One extra bit so a full buffer (count == DEPTH) is representable.
  localparam int CNT_W = IDX_W + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             len_error_q, len_error_d;

  logic             wr_en;
  logic [EXP_W-1:0] rd_data;
  logic             full_beat;
  logic             last_hit;

  softmax_exp_buffer #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(count_q[IDX_W-1:0]),
    .wr_data(in_data),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

  assign full_beat = (count_q == CNT_W'(DEPTH - 1));
  assign last_hit  = ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      sum_q       <= '0;
      rd_ptr_q    <= '0;
      len_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      rd_ptr_q    <= rd_ptr_d;
      len_error_q <= len_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sum_d       = sum_q;
    rd_ptr_d    = rd_ptr_q;
    len_error_d = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
          sum_d   = sum_q + SUM_W'(in_data);
          if (in_last || full_beat) begin
            state_d     = DRAIN;
            rd_ptr_d    = '0;
            len_error_d = !in_last;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + IDX_W'(1);
          if (last_hit) begin
            state_d  = ACCUM;
            count_d  = '0;
            sum_d    = '0;
            rd_ptr_d = '0;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Payload outputs are forced to zero outside DRAIN so idle values are defined.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DRAIN);
    out_x     = out_valid ? rd_data : '0;
    out_y     = out_valid ? sum_q : '0;
    out_last  = out_valid && last_hit;
    out_index = out_valid ? rd_ptr_q : '0;
    zero_sum  = out_valid && (sum_q == '0);
    len_error = len_error_q;
  end

  a_y_ge_x: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (out_y >= SUM_W'(out_x)));

  a_no_in_hs_in_drain: assert property (@(posedge clk) disable iff (rst)
    (state_q == DRAIN) |-> !(in_valid && in_ready));

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_x) && $stable(out_y)
      && $stable(out_last) && $stable(out_index) && $stable(zero_sum)));

endmodule

// File: tb/tb_softmax_exp_accumulator.sv
// Bench for softmax_exp_accumulator: DEPTH=64 and DEPTH=4 instances, driven
// from stimulus queues and checked against a per-vector reference model.
module tb_softmax_exp_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // sel=0 routes traffic to the DEPTH=64 instance, sel=1 to the DEPTH=4 one
  logic        sel;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_data;

  logic        a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_out_last, a_zero_sum, a_len_error;
  logic [7:0]  a_out_x;
  logic [31:0] a_out_y;
  logic [5:0]  a_out_index;
  logic        b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_out_last, b_zero_sum, b_len_error;
  logic [7:0]  b_out_x;
  logic [31:0] b_out_y;
  logic [1:0]  b_out_index;

  assign a_in_valid  = in_valid & ~sel;
  assign a_out_ready = out_ready & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign b_out_ready = out_ready & sel;

  softmax_exp_accumulator #(.DEPTH(64)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_x(a_out_x), .out_y(a_out_y),
    .out_last(a_out_last), .out_index(a_out_index), .zero_sum(a_zero_sum),
    .len_error(a_len_error)
  );

  softmax_exp_accumulator #(.DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_x(b_out_x), .out_y(b_out_y),
    .out_last(b_out_last), .out_index(b_out_index), .zero_sum(b_zero_sum),
    .len_error(b_len_error)
  );

  logic        m_in_ready, m_out_valid, m_out_last, m_zero_sum, m_len_error;
  logic [7:0]  m_out_x;
  logic [31:0] m_out_y;
  logic [5:0]  m_out_index;

  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_last  = sel ? b_out_last  : a_out_last;
  assign m_zero_sum  = sel ? b_zero_sum  : a_zero_sum;
  assign m_len_error = sel ? b_len_error : a_len_error;
  assign m_out_x     = sel ? b_out_x     : a_out_x;
  assign m_out_y     = sel ? b_out_y     : a_out_y;
  assign m_out_index = sel ? {4'b0, b_out_index} : a_out_index;

  // ---------------- stimulus and scoreboard ----------------
  logic [7:0]  stim_d[$];
  logic        stim_l[$];
  logic        beat_close[$];
  logic        beat_trunc[$];
  // expected pair: {last, index[7:0], x[7:0], y[31:0]}
  logic [48:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference: split the beat stream into vectors (closed by last or by the
  // DEPTH-th element), sum each vector, and emit one pair per element.
  task automatic build_model(input int depth);
    int          start;
    logic [31:0] s;
    exp_q.delete();
    beat_close.delete();
    beat_trunc.delete();
    start = 0;
    for (int i = 0; i < stim_d.size(); i++) begin
      if (stim_l[i] || (i - start + 1) == depth) begin
        s = 0;
        for (int j = start; j <= i; j++) s = s + 32'(stim_d[j]);
        for (int j = start; j <= i; j++)
          exp_q.push_back({(j == i), 8'(j - start), stim_d[j], s});
        beat_close.push_back(1'b1);
        beat_trunc.push_back(!stim_l[i]);
        start = i + 1;
      end else begin
        beat_close.push_back(1'b0);
        beat_trunc.push_back(1'b0);
      end
    end
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l);
    stim_d.push_back(d);
    stim_l.push_back(l);
  endtask

  task automatic clear_stim();
    stim_d.delete();
    stim_l.delete();
  endtask

  // mode 0: out_ready high; 1: out_ready toggles; 2: random valid and ready
  task automatic run_stream(input string name, input int depth, input int mode);
    int          ip;
    int          cyc;
    logic        exp_open, exp_le, prev_stall;
    logic [48:0] got, saved, want;
    build_model(depth);
    ip = 0; cyc = 0; exp_open = 0; exp_le = 0; prev_stall = 0; saved = '0;
    while ((ip < stim_d.size() || exp_q.size() > 0) && cyc < 4000) begin
      @(posedge clk); #1;
      in_valid  = (ip < stim_d.size()) && (mode != 2 || $urandom_range(0, 3) != 0);
      in_data   = (ip < stim_d.size()) ? stim_d[ip] : 8'h00;
      in_last   = (ip < stim_d.size()) ? stim_l[ip] : 1'b0;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      cyc++;
      got = {m_out_last, 2'b00, m_out_index, m_out_x, m_out_y};
      if (exp_open) begin
        n_vec++;
        if (m_out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL %s first_valid_latency: out_valid=%b required 1", name, m_out_valid);
        end
      end
      exp_open = 0;
      n_vec++;
      if (m_len_error !== exp_le) begin
        n_err++;
        $display("FAIL %s len_error cyc=%0d: got %b required %b", name, cyc, m_len_error, exp_le);
      end
      exp_le = 0;
      if (prev_stall) begin
        n_vec++;
        if (m_out_valid !== 1'b1 || got !== saved) begin
          n_err++;
          $display("FAIL %s stall_stable: got valid=%b pair=%h required 1 %h", name, m_out_valid, got, saved);
        end
      end
      if (m_out_valid === 1'b1) begin
        n_vec++;
        if (m_in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s in_ready_in_drain: got %b required 0", name, m_in_ready);
        end
        if (out_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected_pair: got %h required none", name, got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want || m_zero_sum !== (want[31:0] == 32'd0)) begin
              n_err++;
              $display("FAIL %s pair: got last/idx/x/y=%h zs=%b required %h zs=%b",
                       name, got, m_zero_sum, want, (want[31:0] == 32'd0));
            end
          end
        end
      end
      if (in_valid && m_in_ready === 1'b1) begin
        exp_open = beat_close[ip];
        exp_le   = beat_trunc[ip];
        ip++;
      end
      prev_stall = (m_out_valid === 1'b1) && !out_ready;
      saved = got;
    end
    n_vec++;
    if (cyc >= 4000) begin
      n_err++;
      $display("FAIL %s timeout: %0d beats %0d pairs left required 0", name,
               stim_d.size() - ip, exp_q.size());
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; out_ready = 0;
    @(negedge clk);
    n_vec++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_len_error !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after_drain: in_ready=%b out_valid=%b len_error=%b required 1 0 0",
               name, m_in_ready, m_out_valid, m_len_error);
    end
    clear_stim();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_vec++;
      if ({m_in_ready, m_out_valid, m_out_x, m_out_y, m_out_last, m_out_index, m_zero_sum, m_len_error}
          !== {1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_values sel=%0d: in_ready=%b out_valid=%b x=%0d y=%0d last=%b idx=%0d zs=%b le=%b required 1 0 0 0 0 0 0 0",
                 s, m_in_ready, m_out_valid, m_out_x, m_out_y, m_out_last, m_out_index, m_zero_sum, m_len_error);
      end
    end
    sel = 0;
  endtask

  task automatic test_basic();
    sel = 0;
    push_beat(8'd10, 0); push_beat(8'd20, 0); push_beat(8'd30, 1);
    run_stream("basic", 64, 0);
  endtask

  task automatic test_backpressure();
    sel = 0;
    push_beat(8'd10, 0); push_beat(8'd20, 0); push_beat(8'd30, 1);
    run_stream("backpressure", 64, 1);
  endtask

  task automatic test_full_scale();
    sel = 0;
    for (int i = 0; i < 64; i++) push_beat(8'd255, (i == 63));
    run_stream("full_scale", 64, 0);
  endtask

  task automatic test_truncation();
    sel = 1;
    for (int i = 1; i <= 5; i++) push_beat(8'(i), (i == 5));
    run_stream("truncation", 4, 0);
    sel = 0;
  endtask

  task automatic test_zero_single();
    sel = 0;
    push_beat(8'd0, 1);
    push_beat(8'd7, 1);
    run_stream("zero_single", 64, 0);
  endtask

  task automatic test_random(input int s, input int depth);
    int len;
    sel = s[0];
    for (int v = 0; v < 6; v++) begin
      len = $urandom_range(1, depth + 2);
      for (int i = 0; i < len; i++)
        push_beat(($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255)),
                  (i == len - 1) && ($urandom_range(0, 3) != 0));
    end
    push_beat(8'($urandom_range(0, 255)), 1'b1);
    run_stream(s[0] ? "random_d4" : "random_d64", depth, 2);
    sel = 0;
  endtask

  task automatic test_reset_mid_drain();
    int   cyc;
    logic found;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1; in_data = 8'(40 + i); in_last = (i == 2); out_ready = 0;
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; out_ready = 1;
    found = 0; cyc = 0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (m_out_valid === 1'b1 && m_out_index === 6'd1) found = 1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_drain_reach: out_index 1 not seen, required within 20 cycles");
    end
    #1 rst = 1;
    #1;
    n_vec++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_out_index !== 6'd0) begin
      n_err++;
      $display("FAIL async_reset_mid_drain: out_valid=%b in_ready=%b idx=%0d required 0 1 0",
               m_out_valid, m_in_ready, m_out_index);
    end
    out_ready = 0;
    @(posedge clk); #1 rst = 0;
    push_beat(8'd5, 0); push_beat(8'd5, 1);
    run_stream("after_reset", 64, 0);
  endtask

  initial begin
    rst = 1; sel = 0;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1 rst = 0;
    test_basic();
    test_backpressure();
    test_full_scale();
    test_truncation();
    test_zero_single();
    test_random(0, 64);
    test_random(1, 4);
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
